// File: rtl/ps2_key_sequencer_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package ps2_key_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;

    // Held-key identity: extended flag above the raw code, matching held_code.
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_t;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Key-event valid/ready channel from the sequencer to its consumers.
interface ps2_key_sequencer_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_repeat, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_break, ev_repeat, output ev_ready);
endinterface

// File: rtl/ps2_key_sequencer.sv
// Purpose: pops PS/2 scan bytes, folds E0/F0 prefixes into key events, tracks held key and press count.
// Latency: event valid 3 cycles after ready is sampled in IDLE; 3 cycles per prefix, 4 per code byte.
// Backpressure: no byte is fetched while an event waits in EMIT; the keyboard FIFO absorbs the stall.
module ps2_key_sequencer
    import ps2_key_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic                     overflow,
    input  logic [7:0]               data,
    output logic                     nextdata_n,
    ps2_key_sequencer_if.master      ev,
    output logic [CNT_W-1:0]         press_count,
    output logic                     held_valid,
    output logic [8:0]               held_code,
    output logic                     ovf_seen
);

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_f;
    logic       brk_f;
    key_t       cur_key;
    logic       key_hit;

    assign cur_key = '{ext: ext_f, code: byte_r};
    assign key_hit = held_valid && (held_code == cur_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_r       <= 8'h00;
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
            nextdata_n   <= 1'b1;
            ev.ev_valid  <= 1'b0;
            ev.ev_code   <= 8'h00;
            ev.ev_ext    <= 1'b0;
            ev.ev_break  <= 1'b0;
            ev.ev_repeat <= 1'b0;
            press_count  <= '0;
            held_valid   <= 1'b0;
            held_code    <= 9'h000;
            ovf_seen     <= 1'b0;
        end else begin
            ovf_seen <= ovf_seen | overflow;
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_r     <= data;
                        nextdata_n <= 1'b0;
                        state      <= POP;
                    end
                end
                // ready is not looked at again until the FIFO has seen the pop
                POP: begin
                    nextdata_n <= 1'b1;
                    state      <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    case (byte_r)
                        PS2_PREFIX_EXT: ext_f <= 1'b1;
                        PS2_PREFIX_BRK: brk_f <= 1'b1;
                        PS2_PAUSE: begin
                            ext_f <= 1'b0;
                            brk_f <= 1'b0;
                        end
                        default: begin
                            ext_f        <= 1'b0;
                            brk_f        <= 1'b0;
                            ev.ev_valid  <= 1'b1;
                            ev.ev_code   <= byte_r;
                            ev.ev_ext    <= ext_f;
                            ev.ev_break  <= brk_f;
                            ev.ev_repeat <= !brk_f && key_hit;
                            state        <= EMIT;
                            // a release of some other key leaves the held key alone
                            if (brk_f) begin
                                if (key_hit) held_valid <= 1'b0;
                            end else if (!key_hit) begin
                                held_code   <= cur_key;
                                held_valid  <= 1'b1;
                                press_count <= press_count + CNT_W'(1);
                            end
                        end
                    endcase
                end
                EMIT: begin
                    if (ev.ev_ready) begin
                        ev.ev_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
